output_pacer: RTL and testbench
===============================

OUTPUT_PACER -- requirements
Module: output_pacer

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: minimum cycles an updated output is held before the next update is accepted.
REQ-002 Parameter RATE_WINDOW, default 100: length of the update-rate measurement window, in cycles.
REQ-003 Parameter RATE_THRESHOLD, default 10: maximum accepted updates per window.
REQ-004 Parameter COOLDOWN_CYCLES, default 25_000_000: blanking duration after a rate violation (1 s at 25 MHz).
REQ-005 Parameter SAFE_VALUE, default 8'h00: value driven on signal_out while blanked.
REQ-006 clk  input  1  single system clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 data_in  input  8  requested output value.
REQ-009 data_valid  input  1  data_in holds a request.
REQ-010 data_ready  output  1  block accepts a request this cycle.
REQ-011 signal_out  output  8  paced, registered output value.
REQ-012 blanked  output  1  high while in COOLDOWN (signal_out forced to SAFE_VALUE).

Function
REQ-013 The FSM SHALL have states IDLE, HOLD and COOLDOWN; data_ready SHALL be 1 only in IDLE.
REQ-014 A request is accepted on an edge where data_valid and data_ready are both 1; data_in SHALL be sampled on that edge only.
REQ-015 On accept with data_in equal to signal_out, the FSM SHALL stay in IDLE, with no update counted and no hold started.
REQ-016 On accept with data_in different from signal_out and update_count < RATE_THRESHOLD:
 - signal_out SHALL take data_in on that edge (zero added latency);
 - update_count SHALL increment;
 - the FSM SHALL enter HOLD.
REQ-017 HOLD SHALL last exactly HOLD_CYCLES cycles, then return to IDLE, so consecutive updates are at least HOLD_CYCLES+1 cycles apart (5 by default).
REQ-018 On accept with data_in different from signal_out and update_count == RATE_THRESHOLD:
 - signal_out SHALL load SAFE_VALUE;
 - blanked SHALL go to 1;
 - the FSM SHALL enter COOLDOWN;
 - the request SHALL be discarded.
REQ-019 COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles, then return to IDLE with blanked=0, update_count=0 and window counter=0; signal_out SHALL stay SAFE_VALUE until the next update.
REQ-020 The window counter SHALL run 0..RATE_WINDOW-1 and wrap in IDLE and HOLD; on wrap, update_count SHALL clear; the counter SHALL hold at 0 in COOLDOWN.
REQ-021 If a wrap and an update coincide on the same edge, update_count SHALL become 1: the update counts in the new window.
REQ-022 Counter widths SHALL be $clog2-sized to their parameter; none SHALL wrap unintentionally.
REQ-023 data_in changes while data_valid=0 or data_ready=0 SHALL have no effect.

Reset
REQ-024 While rst_n=0, the block SHALL asynchronously force:
 - FSM state = IDLE;
 - signal_out = SAFE_VALUE;
 - blanked = 0;
 - data_ready = 1 (after release);
 - all counters = 0.
REQ-025 Reset asserted mid-HOLD or mid-COOLDOWN SHALL abort that state immediately; no residual hold or cooldown time SHALL remain after release.

Configuration
REQ-026 With OUTPUT_PACER_STICKY_EN defined, COOLDOWN SHALL never expire: blanked stays 1, data_ready stays 0 and signal_out stays SAFE_VALUE until rst_n is asserted.
REQ-027 Without OUTPUT_PACER_STICKY_EN, COOLDOWN SHALL expire as in REQ-019.

Verification (bench uses HOLD_CYCLES=4, RATE_WINDOW=100, RATE_THRESHOLD=10, COOLDOWN_CYCLES=50)
REQ-028 Reset release, then valid with data_in=8'hA5 -> signal_out=8'hA5 after the accepting edge; data_ready=0 for exactly 4 cycles, then 1.
REQ-029 data_valid held high with alternating 8'h01/8'h02 -> accepts exactly 5 cycles apart; signal_out never changes within a hold.
REQ-030 Request equal to current signal_out (8'hA5 twice) -> no HOLD entered; update_count unchanged; data_ready stays 1.
REQ-031 11 distinct updates within one window -> first 10 appear on signal_out; the 11th yields signal_out=8'h00 and blanked=1 for 50 cycles, then data_ready=1 and blanked=0.
REQ-032 10 updates ending at window cycle 99, 11th at the wrap edge -> accepted with update_count=1 and no blanking.
REQ-033 rst_n pulsed low mid-COOLDOWN -> blanked=0 and data_ready=1 immediately after release; with OUTPUT_PACER_STICKY_EN, blanking persists past 50 cycles until that reset.

Source files
------------

// File: rtl/output_pacer_if.sv
`default_nettype none
// ============================================================================
// Module      : output_pacer_if
// Description : Request/response bundle between a producer of requested
//               output values and the output_pacer block.
// Revision    : 1.0 - initial release
// ============================================================================
interface output_pacer_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] signal_out;
  logic       blanked;

  // Producer side: offers values, observes pacing and the paced output
  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  signal_out,
    input  blanked
  );

  // Pacer side
  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output signal_out,
    output blanked
  );
endinterface
`default_nettype wire

// File: rtl/output_pacer.sv
`default_nettype none
// ============================================================================
// Module      : output_pacer
// Description : Rate-limits updates of a registered 8-bit output. Each
//               accepted change is held for HOLD_CYCLES cycles; more than
//               RATE_THRESHOLD changes inside one RATE_WINDOW forces the
//               output to SAFE_VALUE for COOLDOWN_CYCLES cycles.
//               Optional build macro OUTPUT_PACER_STICKY_EN: once blanked,
//               the block stays blanked until rst_n is asserted.
//               HOLD_CYCLES and COOLDOWN_CYCLES are expected to be >= 1.
// Revision    : 1.0 - initial release
// ============================================================================
module output_pacer #(
  parameter int         HOLD_CYCLES     = 4,
  parameter int         RATE_WINDOW     = 100,
  parameter int         RATE_THRESHOLD  = 10,
  parameter int         COOLDOWN_CYCLES = 25_000_000,
  parameter logic [7:0] SAFE_VALUE      = 8'h00
) (
  input  wire           clk,
  input  wire           rst_n,
  output_pacer_if.slave bus
);

  localparam int c_WIN_W   = (RATE_WINDOW > 1) ? $clog2(RATE_WINDOW) : 1;
  localparam int c_CNT_W   = (RATE_THRESHOLD > 0) ? $clog2(RATE_THRESHOLD + 1) : 1;
  localparam int c_TMR_MAX = (HOLD_CYCLES > COOLDOWN_CYCLES) ? HOLD_CYCLES : COOLDOWN_CYCLES;
  // Timer counts down from (duration - 1) to 0, so it never holds the full duration
  localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;

  localparam logic [c_WIN_W-1:0] c_WIN_LAST  = c_WIN_W'(RATE_WINDOW - 1);
  localparam logic [c_WIN_W-1:0] c_WIN_ONE   = c_WIN_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(RATE_THRESHOLD);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
  localparam logic [c_TMR_W-1:0] c_HOLD_LOAD = c_TMR_W'(HOLD_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_COOL_LOAD = c_TMR_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_TMR_W-1:0] r_tmr;
  logic [c_WIN_W-1:0] r_win_cnt;
  logic [c_CNT_W-1:0] r_upd_cnt;
  logic [7:0]         r_signal_out;
  logic               r_blanked;
  logic               r_data_ready;

  logic               w_accept;
  logic               w_differs;
  logic               w_wrap;
  logic [c_CNT_W-1:0] w_cnt_eff;
  logic               w_under_limit;
  logic               w_update;
  logic               w_violate;

  // data_ready is a registered copy of (state == IDLE), so it gates acceptance
  assign w_accept      = bus.data_valid & r_data_ready;
  assign w_differs     = (bus.data_in != r_signal_out);
  assign w_wrap        = (r_state != ST_COOLDOWN) && (r_win_cnt == c_WIN_LAST);
  // On a wrap edge the old window's count is discarded before the limit check,
  // so an update landing on that edge is the first of the new window
  assign w_cnt_eff     = w_wrap ? '0 : r_upd_cnt;
  assign w_under_limit = (w_cnt_eff < c_CNT_LIMIT);
  assign w_update      = w_accept & w_differs & w_under_limit;
  assign w_violate     = w_accept & w_differs & ~w_under_limit;

  assign bus.data_ready = r_data_ready;
  assign bus.signal_out = r_signal_out;
  assign bus.blanked    = r_blanked;

  // Rate-measurement window and per-window update count; both parked at 0 while blanked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt <= '0;
      r_upd_cnt <= '0;
    end else if (r_state == ST_COOLDOWN) begin
      r_win_cnt <= '0;
      r_upd_cnt <= '0;
    end else begin
      r_win_cnt <= w_wrap ? '0 : (r_win_cnt + c_WIN_ONE);
      r_upd_cnt <= w_update ? (w_cnt_eff + c_CNT_ONE) : w_cnt_eff;
    end
  end

  // Pacing FSM with registered output value, blanking flag and ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_tmr        <= '0;
      r_signal_out <= SAFE_VALUE;
      r_blanked    <= 1'b0;
      r_data_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_update) begin
            r_signal_out <= bus.data_in;
            r_tmr        <= c_HOLD_LOAD;
            r_state      <= ST_HOLD;
            r_data_ready <= 1'b0;
          end else if (w_violate) begin
            // The offending request is dropped; the output goes to its safe value
            r_signal_out <= SAFE_VALUE;
            r_blanked    <= 1'b1;
            r_tmr        <= c_COOL_LOAD;
            r_state      <= ST_COOLDOWN;
            r_data_ready <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (r_tmr == '0) begin
            r_state      <= ST_IDLE;
            r_data_ready <= 1'b1;
          end else begin
            r_tmr <= r_tmr - c_TMR_ONE;
          end
        end
        ST_COOLDOWN: begin
`ifdef OUTPUT_PACER_STICKY_EN
          // Latched fault: only rst_n leaves this state
          r_state      <= ST_COOLDOWN;
          r_blanked    <= 1'b1;
          r_data_ready <= 1'b0;
`else
          if (r_tmr == '0) begin
            // signal_out keeps SAFE_VALUE until the next accepted update
            r_state      <= ST_IDLE;
            r_blanked    <= 1'b0;
            r_data_ready <= 1'b1;
          end else begin
            r_tmr <= r_tmr - c_TMR_ONE;
          end
`endif
        end
        default: begin
          r_state      <= ST_IDLE;
          r_blanked    <= 1'b0;
          r_data_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_pacer.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_pacer
// Description : Directed self-checking bench for output_pacer with
//               HOLD_CYCLES=4, RATE_WINDOW=100, RATE_THRESHOLD=10,
//               COOLDOWN_CYCLES=50. Honours OUTPUT_PACER_STICKY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_pacer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  output_pacer_if bus ();

  output_pacer #(
    .HOLD_CYCLES     (4),
    .RATE_WINDOW     (100),
    .RATE_THRESHOLD  (10),
    .COOLDOWN_CYCLES (50),
    .SAFE_VALUE      (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    bus.data_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out",   32'(bus.signal_out), 32'h00);
    chk("rst_async_blank", 32'(bus.blanked),    32'd0);
    chk("rst_async_ready", 32'(bus.data_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.data_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.data_ready), 32'd1);
  endtask

  task automatic accept(input logic [7:0] val);
    wait_ready("ready_timeout");
    bus.data_in    = val;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] nxt;
    int         last;
    int         nchg;
    int         n;

    bus.data_in    = 8'h00;
    bus.data_valid = 1'b0;
    tick();

    // ---- first update after reset, hold length ----
    do_reset();
    chk("idle_ready", 32'(bus.data_ready), 32'd1);
    chk("idle_out",   32'(bus.signal_out), 32'h00);
    bus.data_in    = 8'hA5;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    chk("a5_out", 32'(bus.signal_out), 32'hA5);
    n = 0;
    while (bus.data_ready === 1'b0 && n < 20) begin
      n++;
      tick();
    end
    chk("hold_len",      32'(n),              32'd4);
    chk("hold_out_kept", 32'(bus.signal_out), 32'hA5);

    // ---- repeated request equal to the current output ----
    bus.data_in    = 8'hA5;
    bus.data_valid = 1'b1;
    tick();
    chk("eq_ready1", 32'(bus.data_ready), 32'd1);
    chk("eq_out1",   32'(bus.signal_out), 32'hA5);
    tick();
    chk("eq_ready2", 32'(bus.data_ready), 32'd1);
    bus.data_valid = 1'b0;

    // ---- nine more distinct updates (10 in window), then a violation ----
    for (int i = 0; i < 9; i++) begin
      accept(8'(8'h10 + i));
      chk("upd_out", 32'(bus.signal_out), 32'(8'h10 + i));
    end
    chk("pre_viol_blank", 32'(bus.blanked), 32'd0);
    accept(8'h77);
    chk("viol_out",   32'(bus.signal_out), 32'h00);
    chk("viol_blank", 32'(bus.blanked),    32'd1);
    chk("viol_ready", 32'(bus.data_ready), 32'd0);
    bus.data_in    = 8'h55;
    bus.data_valid = 1'b1;
`ifdef OUTPUT_PACER_STICKY_EN
    repeat (80) tick();
    chk("sticky_blank", 32'(bus.blanked),    32'd1);
    chk("sticky_ready", 32'(bus.data_ready), 32'd0);
    chk("sticky_out",   32'(bus.signal_out), 32'h00);
`else
    n = 1;
    while (bus.blanked === 1'b1 && n < 200) begin
      tick();
      if (bus.blanked === 1'b1) n++;
    end
    chk("cool_len",   32'(n),              32'd50);
    chk("cool_ready", 32'(bus.data_ready), 32'd1);
    chk("cool_out",   32'(bus.signal_out), 32'h00);
    tick();
    chk("post_cool_out",   32'(bus.signal_out), 32'h55);
    chk("post_cool_blank", 32'(bus.blanked),    32'd0);
`endif
    bus.data_valid = 1'b0;

    // ---- continuous valid with alternating data, garbage during hold ----
    do_reset();
    bus.data_valid = 1'b1;
    nxt  = 8'h01;
    prev = bus.signal_out;
    last = 0;
    nchg = 0;
    repeat (30) begin
      bus.data_in = (bus.data_ready === 1'b1) ? nxt : 8'($urandom);
      tick();
      if (bus.signal_out !== prev) begin
        chk("alt_val", 32'(bus.signal_out), 32'(nxt));
        if (nchg > 0) chk("alt_gap", 32'(cyc - last), 32'd5);
        last = cyc;
        nchg++;
        nxt  = (nxt == 8'h01) ? 8'h02 : 8'h01;
        prev = bus.signal_out;
      end
    end
    bus.data_valid = 1'b0;
    chk("alt_count", 32'(nchg), 32'd6);

    // ---- ten updates, then one on the window wrap edge ----
    do_reset();
    for (int i = 0; i < 10; i++) accept(8'(8'h20 + i));
    chk("pre_wrap_out", 32'(bus.signal_out), 32'h29);
    while (cyc < 99) tick();
    accept(8'h60);
    chk("wrap_cyc",   32'(cyc),            32'd100);
    chk("wrap_out",   32'(bus.signal_out), 32'h60);
    chk("wrap_blank", 32'(bus.blanked),    32'd0);
    for (int i = 0; i < 9; i++) accept(8'(8'h61 + i));
    chk("win2_out",   32'(bus.signal_out), 32'h69);
    chk("win2_blank", 32'(bus.blanked),    32'd0);
    accept(8'h7A);
    chk("win2_viol_blank", 32'(bus.blanked),    32'd1);
    chk("win2_viol_out",   32'(bus.signal_out), 32'h00);

    // ---- reset pulse in the middle of cooldown ----
    repeat (10) tick();
    chk("cool_mid_blank", 32'(bus.blanked), 32'd1);
    do_reset();
    chk("rel_ready", 32'(bus.data_ready), 32'd1);
    chk("rel_blank", 32'(bus.blanked),    32'd0);
    bus.data_in    = 8'h44;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    chk("rel_accept", 32'(bus.signal_out), 32'h44);

    // ---- reset pulse in the middle of hold ----
    tick();
    chk("mid_hold_ready", 32'(bus.data_ready), 32'd0);
    do_reset();
    chk("hold_rel_ready", 32'(bus.data_ready), 32'd1);
    bus.data_in    = 8'h45;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    chk("hold_rel_accept", 32'(bus.signal_out), 32'h45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: observed=time limit reached required=finish before limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
